// File: rtl/lcd_pkg.sv
// Shared definitions for the ILI9341-subset bus responder: opcodes, FSM states
// and default panel geometry.
package lcd_pkg;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [7:0] COLMOD_RST = 8'h66;
  localparam logic [7:0] MADCTL_RST = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_PARAM1,
    ST_RAMWR,
    ST_IGNORE
  } state_t;

  // Window coordinates are 9 bits: only bit 0 of the high parameter byte survives.
  function automatic logic [8:0] join9(input logic hi0, input logic [7:0] lo);
    return {hi0, lo};
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// 8080-style write bus between pixel_updater (master) and the display responder (slave).
interface lcd_bus_responder_if;
  logic       wr;
  logic       dcx;
  logic [7:0] D;

  modport master (output wr, output dcx, output D);
  modport slave  (input wr, input dcx, input D);
endinterface

// File: rtl/lcd_addr_counter.sv
// Column/page window registers and the raster address counter that walks them.
module lcd_addr_counter
  import lcd_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_win_reset,
  input  logic       load,
  input  logic       step,
  input  logic       set_col,
  input  logic       set_page,
  input  logic [8:0] i_start,
  input  logic [8:0] i_end,
  output logic [8:0] o_x,
  output logic [8:0] o_y
);

  logic [8:0] r_xs, r_xe, r_ys, r_ye;
  logic [8:0] r_x, r_y;
  logic [8:0] w_xlast, w_ylast;

  // A reversed window collapses to the single column/row at its start.
  assign w_xlast = (r_xs > r_xe) ? r_xs : r_xe;
  assign w_ylast = (r_ys > r_ye) ? r_ys : r_ye;

  assign o_x = r_x;
  assign o_y = r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xs <= '0;
      r_xe <= 9'(H_RES - 1);
      r_ys <= '0;
      r_ye <= 9'(V_RES - 1);
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_win_reset) begin
      r_xs <= '0;
      r_xe <= 9'(H_RES - 1);
      r_ys <= '0;
      r_ye <= 9'(V_RES - 1);
    end else begin
      if (set_col) begin
        r_xs <= i_start;
        r_xe <= i_end;
      end
      if (set_page) begin
        r_ys <= i_start;
        r_ye <= i_end;
      end
      if (load) begin
        r_x <= r_xs;
        r_y <= r_ys;
      end else if (step) begin
        if (r_x < w_xlast) begin
          r_x <= r_x + 9'd1;
        end else begin
          r_x <= r_xs;
          r_y <= (r_y < w_ylast) ? r_y + 9'd1 : r_ys;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side responder: detects write strobes, decodes the command stream and
// emits one registered pixel write per completed RGB565 pixel.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_bus_responder_if.slave    bus,
  output logic                  pix_valid,
  output logic [8:0]            pix_x,
  output logic [8:0]            pix_y,
  output logic [15:0]           pix_data,
  output logic                  disp_on,
  output logic                  sleep_out,
  output logic [7:0]            colmod,
  output logic [7:0]            madctl,
  output logic [1:0]            err
);

  logic       r_wr_s, r_wr_q, r_dcx_s;
  logic [7:0] r_d_s;
  state_t     r_state;
  logic [1:0] r_pidx;
  logic       r_start_hi, r_end_hi, r_is_colmod, r_toggle;
  logic [7:0] r_start_lo, r_hi_byte;

  logic       w_strobe, w_cmd, w_data, w_in_range;
  logic       w_load, w_step, w_set_col, w_set_page, w_win_reset;
  logic [8:0] w_x, w_y;

  // Sampled bus is one edge old, so a strobe seen at edge k acts at edge k+1.
  assign w_strobe = r_wr_s & ~r_wr_q;
  assign w_cmd    = w_strobe & ~r_dcx_s;
  assign w_data   = w_strobe &  r_dcx_s;

  assign w_load      = w_cmd && (r_d_s == CMD_RAMWR);
  assign w_win_reset = w_cmd && (r_d_s == CMD_SWRESET);
  assign w_step      = w_data && (r_state == ST_RAMWR) && r_toggle;
  assign w_set_col   = w_data && (r_state == ST_CASET) && (r_pidx == 2'd3);
  assign w_set_page  = w_data && (r_state == ST_PASET) && (r_pidx == 2'd3);
  assign w_in_range  = ({1'b0, w_x} < 10'(H_RES)) && ({1'b0, w_y} < 10'(V_RES));

  lcd_addr_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .i_win_reset (w_win_reset),
    .load        (w_load),
    .step        (w_step),
    .set_col     (w_set_col),
    .set_page    (w_set_page),
    .i_start     (join9(r_start_hi, r_start_lo)),
    .i_end       (join9(r_end_hi, r_d_s)),
    .o_x         (w_x),
    .o_y         (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_s  <= 1'b1;
      r_wr_q  <= 1'b1;
      r_dcx_s <= 1'b0;
      r_d_s   <= '0;
    end else begin
      r_wr_s  <= bus.wr;
      r_wr_q  <= r_wr_s;
      r_dcx_s <= bus.dcx;
      r_d_s   <= bus.D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pidx      <= '0;
      r_start_hi  <= 1'b0;
      r_start_lo  <= '0;
      r_end_hi    <= 1'b0;
      r_is_colmod <= 1'b0;
      r_toggle    <= 1'b0;
      r_hi_byte   <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      disp_on     <= 1'b0;
      sleep_out   <= 1'b0;
      colmod      <= COLMOD_RST;
      madctl      <= MADCTL_RST;
      err         <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (w_cmd) begin
        // Any command abandons a half-received pixel.
        r_toggle <= 1'b0;
        r_pidx   <= '0;
        case (r_d_s)
          CMD_CASET:  r_state <= ST_CASET;
          CMD_PASET:  r_state <= ST_PASET;
          CMD_RAMWR:  r_state <= ST_RAMWR;
          CMD_MADCTL: begin
            r_state     <= ST_PARAM1;
            r_is_colmod <= 1'b0;
          end
          CMD_COLMOD: begin
            r_state     <= ST_PARAM1;
            r_is_colmod <= 1'b1;
          end
          CMD_SWRESET: begin
            r_state   <= ST_IDLE;
            disp_on   <= 1'b0;
            sleep_out <= 1'b0;
            colmod    <= COLMOD_RST;
            madctl    <= MADCTL_RST;
          end
          CMD_NOP:     r_state <= ST_IDLE;
          CMD_SLPIN: begin
            r_state   <= ST_IDLE;
            sleep_out <= 1'b0;
          end
          CMD_SLPOUT: begin
            r_state   <= ST_IDLE;
            sleep_out <= 1'b1;
          end
          CMD_DISPOFF: begin
            r_state <= ST_IDLE;
            disp_on <= 1'b0;
          end
          CMD_DISPON: begin
            r_state <= ST_IDLE;
            disp_on <= 1'b1;
          end
          default: begin
            r_state <= ST_IGNORE;
            err[0]  <= 1'b1;
          end
        endcase
      end else if (w_data) begin
        case (r_state)
          ST_CASET, ST_PASET: begin
            r_pidx <= r_pidx + 2'd1;
            case (r_pidx)
              2'd0:    r_start_hi <= r_d_s[0];
              2'd1:    r_start_lo <= r_d_s;
              2'd2:    r_end_hi   <= r_d_s[0];
              default: r_state    <= ST_IDLE;
            endcase
          end
          ST_PARAM1: begin
            if (r_is_colmod) colmod <= r_d_s;
            else             madctl <= r_d_s;
            r_state <= ST_IDLE;
          end
          ST_RAMWR: begin
            if (!r_toggle) begin
              r_hi_byte <= r_d_s;
              r_toggle  <= 1'b1;
            end else begin
              r_toggle <= 1'b0;
              if (w_in_range) begin
                pix_valid <= 1'b1;
                pix_x     <= w_x;
                pix_y     <= w_y;
                pix_data  <= {r_hi_byte, r_d_s};
              end
            end
          end
          ST_IDLE:   err[1] <= 1'b1;
          default:   r_state <= r_state;
        endcase
      end
    end
  end

endmodule
